// File: rtl/sparse_pkg.sv
// sparse_pkg: shared definitions for the sparse-matrix loader/unloader slice.
//   state_t              - loader FSM state encoding
//   ENTRIES_DEF          - default memory depth (entries)
//   BYTES_PER_ENTRY_DEF  - default bytes shifted into one memory entry
//   PTR_W_DEF            - default width of the memory write pointer
//   HDR_BYTES            - bytes in the nnz frame header (big-endian)
package sparse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    LOAD,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int unsigned ENTRIES_DEF         = 64;
  localparam int unsigned BYTES_PER_ENTRY_DEF = 8;
  localparam int unsigned PTR_W_DEF           = 16;
  localparam int unsigned HDR_BYTES           = 2;

endpackage

// File: rtl/byte_counter.sv
// byte_counter: modulo-MODULUS counter with a wrap pulse.
//   clk    - clock
//   reset  - asynchronous active-low reset
//   clr    - synchronous clear to zero
//   en     - advance by one
//   count  - current count, 0..MODULUS-1
//   wrap   - high when en is set at count MODULUS-1 (count returns to 0)
module byte_counter #(
  parameter int unsigned MODULUS = 8,
  parameter int unsigned W       = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(MODULUS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/sparse_loader.sv
// sparse_loader: parses a framed byte stream holding one sparse nonzero list
// (2-byte big-endian nnz header followed by nnz * BYTES_PER_ENTRY data bytes)
// and issues registered byte writes to the byte-shift memory.
//
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   start               - one-cycle pulse, starts a frame from IDLE/DONE/ERR
//   in_valid/in_ready   - byte stream handshake
//   in_byte, in_last    - stream data, final-byte marker
//   mem_wen             - registered write enable (1 cycle after transfer)
//   mem_writePtr        - registered entry index (zero-extended entry_count)
//   mem_inData          - registered byte to memory
//   nnz                 - header value latched for the current frame
//   entry_count         - entries fully written so far
//   busy, done, error   - status decoded from the FSM state
//
// Optional build macro SPARSE_LOADER_CHECKSUM_EN: the frame carries one extra
// trailer byte (XOR of header and data bytes) checked in state CHK; in_last
// then marks the trailer instead of the last data byte.
module sparse_loader
  import sparse_pkg::*;
#(
  parameter int unsigned ENTRIES         = ENTRIES_DEF,
  parameter int unsigned BYTES_PER_ENTRY = BYTES_PER_ENTRY_DEF,
  parameter int unsigned PTR_W           = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             mem_wen,
  output logic [PTR_W-1:0] mem_writePtr,
  output logic [7:0]       mem_inData,
  output logic [15:0]      nnz,
  output logic [15:0]      entry_count,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned CNT_W = (BYTES_PER_ENTRY > 1) ? $clog2(BYTES_PER_ENTRY) : 1;

  state_t state, state_n;

  logic             xfer;
  logic             start_go;
  logic             load_xfer;
  logic [15:0]      hdr_nnz;
  logic             last_entry;
  logic             last_byte;
  logic             frame_end;
  logic [CNT_W-1:0] bc_count;
  logic             bc_wrap;

  assign busy     = (state == HDR_HI) || (state == HDR_LO) || (state == LOAD) || (state == CHK);
  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign in_ready = busy;

  assign xfer      = in_valid && in_ready;
  assign start_go  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign load_xfer = xfer && (state == LOAD);

  // Header value as it will look once the low byte is latched this cycle.
  assign hdr_nnz    = {nnz[15:8], in_byte};
  assign last_entry = (entry_count == (nnz - 16'd1));
  assign last_byte  = (bc_count == CNT_W'(BYTES_PER_ENTRY - 1));
  assign frame_end  = load_xfer && last_byte && last_entry;

  byte_counter #(
    .MODULUS (BYTES_PER_ENTRY),
    .W       (CNT_W)
  ) u_byte_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (start_go),
    .en    (load_xfer),
    .count (bc_count),
    .wrap  (bc_wrap)
  );

`ifdef SPARSE_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (start_go) begin
      csum <= '0;
    end else if (xfer && (state != CHK)) begin
      csum <= csum ^ in_byte;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_n = HDR_HI;
      end
      HDR_HI: begin
        if (xfer) state_n = in_last ? ERR : HDR_LO;
      end
      HDR_LO: begin
        if (xfer) begin
          if (hdr_nnz == 16'd0) begin
`ifdef SPARSE_LOADER_CHECKSUM_EN
            state_n = in_last ? ERR : CHK;
`else
            state_n = in_last ? DONE : ERR;
`endif
          end else if (32'(hdr_nnz) > ENTRIES) begin
            state_n = ERR;
          end else begin
            state_n = in_last ? ERR : LOAD;
          end
        end
      end
      LOAD: begin
        if (frame_end) begin
`ifdef SPARSE_LOADER_CHECKSUM_EN
          state_n = in_last ? ERR : CHK;
`else
          state_n = in_last ? DONE : ERR;
`endif
        end else if (load_xfer && in_last) begin
          state_n = ERR;
        end
      end
      CHK: begin
`ifdef SPARSE_LOADER_CHECKSUM_EN
        if (xfer) state_n = (in_last && (in_byte == csum)) ? DONE : ERR;
`else
        state_n = ERR;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // The pointer registered with a byte is the entry_count before any
  // increment, so the final byte of an entry still targets that entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wen      <= 1'b0;
      mem_writePtr <= '0;
      mem_inData   <= '0;
      nnz          <= '0;
      entry_count  <= '0;
    end else begin
      mem_wen <= 1'b0;
      if (start_go) begin
        nnz          <= '0;
        entry_count  <= '0;
        mem_writePtr <= '0;
      end
      if (xfer && (state == HDR_HI)) begin
        nnz <= {in_byte, 8'h00};
      end
      if (xfer && (state == HDR_LO)) begin
        nnz[7:0] <= in_byte;
      end
      if (load_xfer) begin
        mem_wen      <= 1'b1;
        mem_inData   <= in_byte;
        mem_writePtr <= PTR_W'(entry_count);
        if (bc_wrap) entry_count <= entry_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/sparse_loader.md
Name: sparse_loader

Overview:
- Upstream feeder for the 64-entry byte-shift memory.
- Accepts a framed byte stream carrying one sparse-matrix nonzero list, parses a 2-byte nnz header, then issues byte writes (wen/writePtr/inData) so each memory entry accumulates BYTES_PER_ENTRY bytes.
- Reports completion, entry count and framing errors to the controller.

Parameters:
- ENTRIES, 64, memory depth; nnz above this is an error.
- BYTES_PER_ENTRY, 8, bytes shifted into one entry (64-bit entry / 8-bit bus).
- PTR_W, 16, width of the write pointer driven to memory.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a frame when in IDLE or DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_ready  output  1  byte-stream ready; a byte transfers when in_valid && in_ready.
- in_byte  input  8  stream data.
- in_last  input  1  marks the final byte of a frame.
- mem_wen  output  1  write enable to memory, registered.
- mem_writePtr  output  PTR_W  entry index, registered.
- mem_inData  output  8  byte to memory, registered.
- nnz  output  16  header value latched for the current frame.
- entry_count  output  16  entries fully written so far.
- busy  output  1  high in HDR_HI, HDR_LO and LOAD.
- done  output  1  high while in DONE.
- error  output  1  high while in ERR.

Behaviour:
- Reset (async assert, sync-released state) outputs: all 0; state IDLE; byte counter 0.
- States: IDLE, HDR_HI, HDR_LO, LOAD, DONE, ERR.
- IDLE/DONE/ERR + start:
  - -> HDR_HI.
  - Clears nnz, entry_count, byte counter and pointer.
  - done/error drop the next cycle.
- in_ready: 1 in HDR_HI, HDR_LO and LOAD; 0 elsewhere.
- HDR_HI:
  - On transfer, latch nnz[15:8], -> HDR_LO.
  - in_last here -> ERR.
- HDR_LO:
  - On transfer, latch nnz[7:0].
  - Merged nnz == 0: requires in_last, -> DONE; no in_last -> ERR.
  - Merged nnz > ENTRIES -> ERR.
  - Otherwise -> LOAD. in_last with nnz > 0 -> ERR.
- LOAD, per transferred byte:
  - Next cycle mem_wen = 1, mem_inData = byte, mem_writePtr = entry_count (low PTR_W bits).
  - Latency is exactly 1 cycle. mem_wen = 0 in any cycle without a transfer.
- Byte counter counts 0..BYTES_PER_ENTRY-1. At terminal count it wraps to 0 and entry_count increments. The pointer for that last byte is still the old entry.
- Completing entry nnz-1:
  - in_last must be set on that byte -> DONE.
  - in_last earlier -> ERR.
  - No in_last on that byte -> ERR (overlong frame).
  - All bytes of a frame that ends in ERR are still written.
- ERR/DONE are sticky until the next start. Stream bytes are not accepted there (in_ready = 0).
- start while busy: ignored.
- Reset mid-frame: immediate return to IDLE; the partially written entry is left in memory.
- Widths:
  - entry_count and nnz are 16-bit unsigned.
  - Comparison nnz > ENTRIES is unsigned.
  - mem_writePtr is zero-extended entry_count.

Optional Feature:
- SPARSE_LOADER_CHECKSUM_EN defined:
  - One extra trailer byte follows the last data byte; in_last moves to the trailer.
  - Trailer = XOR of all header and data bytes.
  - Trailer is not written to memory.
  - Mismatch -> ERR; match -> DONE.
  - New state CHK between LOAD and DONE.
- Undefined: no trailer; behaviour exactly as above.

Decomposition:
- Package sparse_pkg holds:
  - the state enum typedef;
  - BYTES_PER_ENTRY and ENTRIES defaults;
  - HDR_BYTES = 2.
- One sub-module, byte_counter: modulo-BYTES_PER_ENTRY counter with wrap pulse, reused by the downstream unloader.

Test Plan:
- Header 0x00,0x01 + 8 bytes 0x11..0x18, last on 0x18:
  - 8 writes to ptr 0, data 0x11..0x18, each one cycle after transfer;
  - done = 1, entry_count = 1, nnz = 1.
- nnz = 3, 24 bytes, in_valid toggling every other cycle:
  - ptr sequence 0×8, 1×8, 2×8;
  - no write in idle cycles; done.
- Header 0x00,0x41 (65 > 64): error after second header byte; zero writes; in_ready = 0.
- nnz = 2, in_last on byte 12: error; 12 writes issued; next start with a valid frame -> done.
- Reset asserted after 5 data bytes: all outputs 0 asynchronously; state IDLE; no further writes.
- Checksum build, nnz = 1, trailer correct -> done; trailer off by 1 -> error; 8 writes in both cases.
